// File: rtl/intr_encoder.sv
// Sequential priority encoder: captures a request vector on load and emits the
// index of every set bit, highest first, one per valid/ready transfer.
module intr_encoder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         load,
  output logic [W-1:0] code,
  output logic         valid,
  input  logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W:0]   count
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       state, state_next;
  logic [N-1:0] pending, pending_next;
  logic [W:0]   count_next;
  logic         done_next;
  logic [W-1:0] top_idx;
  logic [N-1:0] top_mask;
  logic         xfer;

  // Priority search works only from the captured vector, so req changes mid-sequence are invisible.
  always_comb begin
    top_idx  = '0;
    top_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (pending[i]) begin
        top_idx = W'(i);
      end
    end
    top_mask[top_idx] = 1'b1;
  end

  assign valid = (state == EMIT);
  assign busy  = (state == EMIT);
  assign code  = valid ? top_idx : '0;
  assign xfer  = valid && ready;

  always_comb begin
    state_next   = state;
    pending_next = pending;
    count_next   = count;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          pending_next = req;
          count_next   = '0;
          if (req != '0) begin
            state_next = EMIT;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      EMIT: begin
        if (xfer) begin
          pending_next = pending & ~top_mask;
          count_next   = (count == (W+1)'(N)) ? count : count + 1'b1;
          if (pending_next == '0) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      count   <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      count   <= count_next;
      done    <= done_next;
    end
  end

endmodule

// File: tb/tb_intr_encoder.sv
// Bench for intr_encoder: directed scenarios plus random vectors and random
// backpressure, checked against a queue of expected indices built per vector.
module tb_intr_encoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       load;
  logic [2:0] code;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       done;
  logic [3:0] count;

  int tests;
  int failures;

  intr_encoder #(.N(8), .W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .load(load), .code(code),
    .valid(valid), .ready(ready), .busy(busy), .done(done), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic load_v, input logic [7:0] req_v, input logic ready_v);
    load  = load_v;
    req   = req_v;
    ready = ready_v;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for the first 3 cycles.
  // inject: keep asserting load with req=8'h01 once two codes have been accepted.
  task automatic runVector(input logic [7:0] v, input int mode, input bit inject);
    int exp_q[$];
    int accepted;
    int cycles;
    int total;
    logic rdy;
    for (int k = 7; k >= 0; k--) begin
      if (v[k]) exp_q.push_back(k);
    end
    total = exp_q.size();
    @(negedge clk);
    applyStimulus(1'b1, v, 1'($urandom_range(0, 1)));
    @(negedge clk);
    if (total == 0) begin
      checkOutput("empty_valid", int'(valid), 0);
      checkOutput("empty_busy", int'(busy), 0);
      checkOutput("empty_done", int'(done), 1);
      checkOutput("empty_count", int'(count), 0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      @(negedge clk);
      checkOutput("empty_done_clear", int'(done), 0);
      checkOutput("empty_valid_after", int'(valid), 0);
      return;
    end
    accepted = 0;
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 200) begin
      checkOutput("emit_valid", int'(valid), 1);
      checkOutput("emit_busy", int'(busy), 1);
      checkOutput("emit_code", int'(code), exp_q[0]);
      checkOutput("emit_done", int'(done), 0);
      checkOutput("emit_count", int'(count), accepted);
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 3) != 0);
        default: rdy = (cycles >= 3);
      endcase
      if (inject && accepted >= 2) applyStimulus(1'b1, 8'h01, rdy);
      else applyStimulus(1'b0, 8'($urandom_range(0, 255)), rdy);
      if (rdy) begin
        void'(exp_q.pop_front());
        accepted++;
      end
      cycles++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      tests++;
      failures++;
      $display("[TB] FAIL timeout observed=%0d pending expected=0", exp_q.size());
    end
    checkOutput("end_valid", int'(valid), 0);
    checkOutput("end_busy", int'(busy), 0);
    checkOutput("end_done", int'(done), 1);
    checkOutput("end_count", int'(count), total);
    checkOutput("end_code", int'(code), 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("done_single", int'(done), 0);
    checkOutput("idle_valid", int'(valid), 0);
    checkOutput("count_hold", int'(count), total);
  endtask

  initial begin
    tests = 0;
    failures = 0;
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", int'(valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_count", int'(count), 0);
    checkOutput("rst_code", int'(code), 0);
    rst_n = 1'b1;

    // Sparse vector, backpressure, empty load, load while busy
    runVector(8'b1010_0100, 0, 1'b0);
    runVector(8'b0001_0011, 2, 1'b0);
    runVector(8'h00, 0, 1'b0);
    runVector(8'hFF, 0, 1'b1);

    // Reset mid-sequence after the code-7 transfer
    @(negedge clk);
    applyStimulus(1'b1, 8'hF0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("mid_first_code", int'(code), 7);
    @(negedge clk);
    checkOutput("mid_second_code", int'(code), 6);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", int'(valid), 0);
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_count", int'(count), 0);
    @(negedge clk);
    checkOutput("mid_rst_no_done", int'(done), 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("mid_rel_no_done", int'(done), 0);
    checkOutput("mid_rel_valid", int'(valid), 0);
    runVector(8'h02, 0, 1'b0);

    // Single-bit sweep
    for (int i = 0; i < 8; i++) begin
      runVector(8'(1 << i), 1, 1'b0);
    end

    // Random vectors with random backpressure and ignored loads
    for (int n = 0; n < 25; n++) begin
      runVector(8'($urandom_range(0, 255)), 1, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
